// File: rtl/io_event_pkg.sv
// Shared types and defaults for the register-file event writer.
// Register indices and the button/collision state encodings.
package io_event_pkg;

    localparam logic [4:0] BTN_REG_DEF    = 5'd20;
    localparam logic [4:0] SCREEN_REG_DEF = 5'd22;
    localparam logic [4:0] COLL_REG_DEF   = 5'd24;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_DEBOUNCE,
        BTN_HELD
    } btn_state_t;

    typedef enum logic {
        COLL_ARMED,
        COLL_LATCHED
    } coll_state_t;

endpackage

// File: rtl/event_debouncer.sv
// Button synchroniser and debouncer.
// Emits one press pulse per debounced press; a release re-arms it.
module event_debouncer
    import io_event_pkg::*;
#(
    parameter int CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          s1;
    logic          s2;
    btn_state_t    state;
    btn_state_t    state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;
    logic          pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= BTN_IDLE;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            state <= state_d;
            cnt   <= cnt_d;
            pulse <= pulse_d;
        end
    end

    // Entering DEBOUNCE is the first stable sample; CYCLES more confirm the press.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pulse_d = 1'b0;
        unique case (state)
            BTN_IDLE: begin
                if (s2) begin
                    state_d = BTN_DEBOUNCE;
                    cnt_d   = '0;
                end
            end
            BTN_DEBOUNCE: begin
                if (!s2) begin
                    state_d = BTN_IDLE;
                end else if (cnt == LAST) begin
                    pulse_d = 1'b1;
                    state_d = BTN_HELD;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            BTN_HELD: begin
                if (!s2) state_d = BTN_IDLE;
            end
            default: state_d = BTN_IDLE;
        endcase
    end

endmodule

// File: rtl/io_event_writer.sv
// Hardware writer for the button, screen-tick and collision registers.
// Data outputs pass CPU write data through unless a hardware strobe is up.
module io_event_writer
    import io_event_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         FRAMES_PER_TICK = 1,
    parameter logic [4:0] BTN_REG         = BTN_REG_DEF,
    parameter logic [4:0] SCREEN_REG      = SCREEN_REG_DEF,
    parameter logic [4:0] COLL_REG        = COLL_REG_DEF
) (
    input  logic        clock,
    input  logic        ctrl_reset_n,
    input  logic        btn_raw,
    input  logic        frame_tick,
    input  logic        collision_raw,
    input  logic        ctrl_writeEnable,
    input  logic [4:0]  ctrl_writeReg,
    input  logic [31:0] data_writeReg,
    output logic [31:0] r20,
    output logic [31:0] r22,
    output logic [31:0] r24,
    output logic        button_signal_reg,
    output logic        screen_signal_reg,
    output logic        collision_signal_reg
);

    localparam int FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_TICK - 1);

    logic          wr_btn_unused;
    logic          wr_screen;
    logic          wr_coll;
    logic [FW-1:0] frame_cnt;
    logic          frame_wrap;
    logic [31:0]   tick_cnt;
    logic          c_s1;
    logic          c_s2;
    logic          c_prev;
    logic          coll_edge;
    logic          coll_fire;
    coll_state_t   coll_state;
    coll_state_t   coll_state_d;

    assign wr_btn_unused = ctrl_writeEnable && (ctrl_writeReg == BTN_REG);
    assign wr_screen     = ctrl_writeEnable && (ctrl_writeReg == SCREEN_REG);
    assign wr_coll       = ctrl_writeEnable && (ctrl_writeReg == COLL_REG);
    assign frame_wrap    = frame_tick && (frame_cnt == F_LAST);
    assign coll_edge     = c_s2 && !c_prev;

    event_debouncer #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (clock),
        .rst_n(ctrl_reset_n),
        .din  (btn_raw),
        .pulse(button_signal_reg)
    );

    // A software write loses to a tick landing in the same cycle.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            frame_cnt            <= '0;
            tick_cnt             <= '0;
            screen_signal_reg    <= 1'b0;
            c_s1                 <= 1'b0;
            c_s2                 <= 1'b0;
            c_prev               <= 1'b0;
            coll_state           <= COLL_ARMED;
            collision_signal_reg <= 1'b0;
        end else begin
            if (frame_tick) frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
            if (frame_wrap) begin
                tick_cnt <= tick_cnt + 32'd1;
            end else if (wr_screen && !screen_signal_reg) begin
                tick_cnt <= data_writeReg;
            end
            screen_signal_reg    <= frame_wrap;
            c_s1                 <= collision_raw;
            c_s2                 <= c_s1;
            c_prev               <= c_s2;
            coll_state           <= coll_state_d;
            collision_signal_reg <= coll_fire;
        end
    end

    always_comb begin
        coll_state_d = coll_state;
        coll_fire    = 1'b0;
        unique case (coll_state)
            COLL_ARMED: begin
                if (coll_edge) begin
                    coll_fire    = 1'b1;
                    coll_state_d = COLL_LATCHED;
                end
            end
            COLL_LATCHED: begin
                if (wr_coll && !collision_signal_reg) coll_state_d = COLL_ARMED;
            end
            default: coll_state_d = COLL_ARMED;
        endcase
    end

    assign r20 = button_signal_reg    ? 32'd1    : data_writeReg;
    assign r22 = screen_signal_reg    ? tick_cnt : data_writeReg;
    assign r24 = collision_signal_reg ? 32'd1    : data_writeReg;

endmodule

// File: tb/tb_io_event_writer.sv
// Scoreboard bench for io_event_writer: event-level model feeds queues,
// a negedge monitor pops and compares whenever a strobe appears.
module tb_io_event_writer;

    localparam int N = 4;
    localparam int F = 2;

    logic        clock = 1'b0;
    logic        ctrl_reset_n;
    logic        btn_raw;
    logic        frame_tick;
    logic        collision_raw;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] r20;
    logic [31:0] r22;
    logic [31:0] r24;
    logic        button_signal_reg;
    logic        screen_signal_reg;
    logic        collision_signal_reg;

    io_event_writer #(
        .DEBOUNCE_CYCLES(N),
        .FRAMES_PER_TICK(F)
    ) dut (
        .clock               (clock),
        .ctrl_reset_n        (ctrl_reset_n),
        .btn_raw             (btn_raw),
        .frame_tick          (frame_tick),
        .collision_raw       (collision_raw),
        .ctrl_writeEnable    (ctrl_writeEnable),
        .ctrl_writeReg       (ctrl_writeReg),
        .data_writeReg       (data_writeReg),
        .r20                 (r20),
        .r22                 (r22),
        .r24                 (r24),
        .button_signal_reg   (button_signal_reg),
        .screen_signal_reg   (screen_signal_reg),
        .collision_signal_reg(collision_signal_reg)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q[3][$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Event-level model state
    int          run      = 0;
    int          fcount   = 0;
    logic [31:0] tc       = 0;
    bit          armed    = 1;
    bit          ch1      = 0;
    bit          ch2      = 0;
    bit          ch3      = 0;
    int          last_inc = -10;
    int          last_col = -10;

    task automatic push(input int w, input int c, input logic [31:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        q[w].push_back(e);
    endtask

    // One clock of stimulus; the model predicts what edge k produces.
    task automatic step(input bit rst, input bit b, input bit ft,
                        input bit c, input bit we,
                        input logic [4:0] wr, input logic [31:0] d);
        int k;
        bit rise;
        bit inc;
        @(posedge clock);
        #1;
        ctrl_reset_n     = rst;
        btn_raw          = b;
        frame_tick       = ft;
        collision_raw    = c;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = d;
        k = cyc + 1;
        if (!rst) begin
            for (int w = 0; w < 3; w++)
                for (int i = q[w].size() - 1; i >= 0; i--)
                    if (q[w][i].cyc >= k - 1) q[w].delete(i);
            run = 0; fcount = 0; tc = 0; armed = 1;
            ch1 = 0; ch2 = 0; ch3 = 0;
            last_inc = -10; last_col = -10;
            return;
        end
        // button: N+1 consecutive high samples make a press
        if (b) begin
            run++;
            if (run == N + 1) push(0, (k - N) + N + 2, 32'd1);
        end else begin
            run = 0;
        end
        // screen
        inc = 0;
        if (ft) begin
            fcount++;
            if (fcount == F) begin
                fcount = 0;
                inc = 1;
            end
        end
        if (inc) begin
            tc = tc + 32'd1;
            push(1, k, tc);
            last_inc = k;
        end else if (we && wr == 5'd22 && last_inc != k - 1) begin
            tc = d;
        end
        // collision: rise at sample k-2 reaches the edge detector now
        rise = ch2 && !ch3;
        if (armed && rise) begin
            armed = 0;
            push(2, k, 32'd1);
            last_col = k;
        end else if (!armed && we && wr == 5'd24 && last_col != k - 1) begin
            armed = 1;
        end
        ch3 = ch2;
        ch2 = ch1;
        ch1 = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 5'd0, 32'h0);
    endtask

    task automatic check_port(input int w, input string nm,
                              input logic s, input logic [31:0] r);
        exp_t e;
        n_chk++;
        if (!ctrl_reset_n) begin
            if (s !== 1'b0 || r !== data_writeReg) begin
                n_fail++;
                $display("FAIL %s reset: strobe=%b r=%h, required strobe=0 r=%h",
                         nm, s, r, data_writeReg);
            end
        end else if (s === 1'b1) begin
            if (q[w].size() == 0) begin
                n_fail++;
                $display("FAIL %s unexpected strobe at cyc %0d r=%h", nm, cyc, r);
            end else begin
                e = q[w].pop_front();
                if (e.cyc != cyc || r !== e.data) begin
                    n_fail++;
                    $display("FAIL %s strobe: cyc=%0d r=%h, required cyc=%0d r=%h",
                             nm, cyc, r, e.cyc, e.data);
                end
            end
        end else begin
            if (s !== 1'b0 || r !== data_writeReg) begin
                n_fail++;
                $display("FAIL %s passthrough: strobe=%b r=%h, required 0 %h",
                         nm, s, r, data_writeReg);
            end
            if (q[w].size() > 0 && q[w][0].cyc <= cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL %s missing strobe: none at cyc %0d, required r=%h at cyc %0d",
                         nm, cyc, q[w][0].data, q[w][0].cyc);
                void'(q[w].pop_front());
            end
        end
    endtask

    always @(negedge clock) begin
        check_port(0, "button", button_signal_reg, r20);
        check_port(1, "screen", screen_signal_reg, r22);
        check_port(2, "collision", collision_signal_reg, r24);
    end

    initial begin
        int   brem;
        bit   blev;
        bit   clev;
        bit   rst;
        bit   we;
        logic [4:0] wr;
        ctrl_reset_n     = 1'b0;
        btn_raw          = 1'b0;
        frame_tick       = 1'b0;
        collision_raw    = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'h0;

        // reset held while all inputs toggle
        for (int i = 0; i < 10; i++)
            step(0, i[0], !i[0], i[1], 1, 5'd22, $urandom);
        idle(12);

        // button: long press with CPU write of 0 landing on the strobe
        for (int i = 0; i < 20; i++)
            step(1, 1, 0, 0, i == N + 3, 5'd20, 32'h0);
        idle(5);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(5);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(5);

        // screen: five frame pulses, rebase to 100, wrap from all-ones
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 0, 0, 5'd0, 32'h0);
            idle(2);
        end
        step(1, 0, 0, 0, 1, 5'd22, 32'd100);
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 1, 0, 0, 5'd0, 32'h0);
            idle(2);
        end
        step(1, 0, 0, 0, 1, 5'd22, 32'hFFFF_FFFF);
        step(1, 0, 1, 0, 0, 5'd0, 32'h0);
        step(1, 0, 1, 0, 0, 5'd0, 32'h0);
        idle(3);

        // collision: fire, ignored rise, ack, fire, ack lost on strobe cycle
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);
        step(1, 0, 0, 0, 1, 5'd24, 32'h0);
        idle(2);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        step(1, 0, 0, 0, 1, 5'd24, 32'h0);
        idle(3);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);
        step(1, 0, 0, 0, 1, 5'd24, 32'h0);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);

        // reset mid-debounce and while latched
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 5'd0, 32'h0);
        step(0, 1, 0, 0, 0, 5'd0, 32'h0);
        step(0, 1, 0, 0, 0, 5'd0, 32'h0);
        idle(10);
        step(1, 0, 0, 1, 0, 5'd0, 32'h0);
        idle(4);

        // randomized traffic
        brem = 0; blev = 0; clev = 0;
        for (int i = 0; i < 3000; i++) begin
            if (brem == 0) begin
                blev = !blev;
                brem = blev ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 6));
            end
            brem--;
            if ($urandom_range(0, 7) == 0) clev = !clev;
            rst = ($urandom_range(0, 499) != 0);
            we  = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0: wr = 5'd20;
                1: wr = 5'd22;
                2: wr = 5'd24;
                default: wr = 5'($urandom);
            endcase
            step(rst, blev, $urandom_range(0, 2) == 0, clev, we, wr, $urandom);
            if (!rst) begin
                blev = 0;
                brem = 0;
            end
        end
        idle(12);

        for (int w = 0; w < 3; w++) begin
            n_chk++;
            if (q[w].size() != 0) begin
                n_fail++;
                $display("FAIL queue %0d drain: %0d pending, required 0", w, q[w].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
